pipe_stage_reg: RTL

//  Generic inter-stage pipeline register (EX/MM and later stages) with valid/ready handshake,
//  2-entry skid buffer, flush, and sticky halt capture. Upstream stage drives a packed payload
//  (control + data fields); downstream stage consumes it. The skid buffer keeps in_ready a

---
 rtl/pipe_stage_reg.sv | 70 +++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline register with valid/ready handshake, 2-entry skid buffer, flush, halt capture and stall counter
module pipe_stage_reg #(
  parameter int WIDTH    = 64,
  parameter int HALT_BIT = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             flush_i,
  output logic             halted_o,
  input  logic             clr_cnt_i,
  output logic [CNT_W-1:0] stall_cnt_o
);
  localparam logic [1:0] EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
  logic             in_ready_q, in_ready_d, halted_q, halted_d, halt_pend_q, halt_pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, issue;
  assign out_valid_o = state_q != EMPTY;
  assign out_data_o  = main_q;
  assign in_ready_o  = in_ready_q;
  assign halted_o    = halted_q;
  assign stall_cnt_o = cnt_q;
  always_comb begin
    accept = in_valid_i & in_ready_q;
    issue  = out_valid_o & out_ready_i;
    state_d = flush_i ? EMPTY :
              state_q == EMPTY ? (accept ? ONE : EMPTY) :
              state_q == ONE ? ((issue & !accept) ? EMPTY : (!issue & accept) ? FULL : ONE) :
              (issue ? ONE : FULL);
    main_d = flush_i ? main_q :
             (state_q == FULL & issue) ? skid_q :
             (accept & (state_q == EMPTY | issue)) ? in_data_i : main_q;
    skid_d = (!flush_i & state_q == ONE & accept & !issue) ? in_data_i : skid_q;
    // Only one halt payload can be resident, so its issue is what clears the pending flag
    halt_pend_d = flush_i ? 1'b0 :
                  (accept & in_data_i[HALT_BIT]) ? 1'b1 :
                  (issue & main_q[HALT_BIT]) ? 1'b0 : halt_pend_q;
    halted_d   = halted_q | (!flush_i & issue & main_q[HALT_BIT]);
    in_ready_d = (state_d != FULL) & !halted_d & !halt_pend_d;
    cnt_d = clr_cnt_i ? '0 :
            (out_valid_o & !out_ready_i & !flush_i & (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      halted_q    <= 1'b0;
      halt_pend_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      halted_q    <= halted_d;
      halt_pend_q <= halt_pend_d;
      cnt_q       <= cnt_d;
    end
  end
endmodule
